// File: rtl/ti_sbox4_pipe_pkg.sv
// Coefficients of the quadratic decomposition S = G o F, the unshared reference table
// and helpers for evaluating one 3-share output and locating nibbles in packed buses.
package ti_sbox4_pkg;

  typedef logic [3:0]        nib_t;
  typedef logic [3:0][3:0]   coef_a_t;  // [coord][j]: linear term x_j
  typedef logic [3:0][15:0]  coef_b_t;  // [coord][4*j+k], j<k: product x_j*x_k

  // F: f0 = 1^x0^x1x2, f1 = x1^x2x3, f2 = x2^x3, f3 = x3
  localparam logic [3:0] F_C0 = 4'b0001;
  localparam coef_a_t    F_A  = {4'b1000, 4'b1100, 4'b0010, 4'b0001};
  localparam coef_b_t    F_B  = {16'h0000, 16'h0000, 16'h0800, 16'h0040};

  // G: g0 = y0, g1 = y0^y1, g2 = y2^y0y1, g3 = 1^y3^y1y2
  localparam logic [3:0] G_C0 = 4'b1000;
  localparam coef_a_t    G_A  = {4'b1000, 4'b0100, 4'b0011, 4'b0001};
  localparam coef_b_t    G_B  = {16'h0040, 16'h0002, 16'h0000, 16'h0000};

  localparam logic [3:0] SBOX_REF [16] = '{
    4'hB, 4'h8, 4'hD, 4'hA, 4'hF, 4'hC, 4'h6, 4'h1,
    4'h7, 4'h4, 4'h9, 4'hE, 4'h5, 4'h2, 4'h0, 4'h3
  };

  function automatic int share_lsb(input int nsbox, input int s, input int n);
    return 4 * nsbox * s + 4 * n;
  endfunction

  // One output share built only from the two other input shares xp, xq.
  function automatic nib_t quad_share(input logic [3:0] c0, input coef_a_t a,
                                      input coef_b_t b, input logic first,
                                      input nib_t xp, input nib_t xq);
    nib_t y;
    logic acc;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      acc = first & c0[c];
      for (int j = 0; j < 4; j++) begin
        if (a[c][j]) acc = acc ^ xp[j];
        for (int k = j + 1; k < 4; k++) begin
          if (b[c][4*j+k]) acc = acc ^ (xp[j] & xp[k]) ^ (xp[j] & xq[k]) ^ (xq[j] & xp[k]);
        end
      end
      y[c] = acc;
    end
    return y;
  endfunction

endpackage

// File: rtl/ti_sbox4_pipe_if.sv
// Share stream interface of the TI S-box layer; ingress and egress ports of the pipe.
interface ti_sbox4_if #(
  parameter int NSBOX = 4
) ();
  // A beat transfers on a rising edge where valid & ready; valid must hold with stable
  // data until that edge, ready may depend combinationally on the downstream ready.
  logic                   in_valid;
  logic                   in_ready;
  logic [12*NSBOX-1:0]    in_shares;
  logic                   out_valid;
  logic                   out_ready;
  logic [12*NSBOX-1:0]    out_shares;

  modport master (
    output in_valid, in_shares, out_ready,
    input  in_ready, out_valid, out_shares
  );

  modport slave (
    input  in_valid, in_shares, out_ready,
    output in_ready, out_valid, out_shares
  );
endinterface

// File: rtl/ti_sbox4_pipe_quad.sv
// One 4-bit quadratic map on 3 Boolean shares, non-complete direct sharing (combinational).
module ti_quad_share4
  import ti_sbox4_pkg::*;
#(
  parameter logic [3:0] C0 = 4'b0000,
  parameter coef_a_t    A  = '0,
  parameter coef_b_t    B  = '0
) (
  input  nib_t x0,
  input  nib_t x1,
  input  nib_t x2,
  output nib_t y0,
  output nib_t y1,
  output nib_t y2
);
  assign y0 = quad_share(C0, A, B, 1'b1, x1, x2);
  assign y1 = quad_share(C0, A, B, 1'b0, x2, x0);
  assign y2 = quad_share(C0, A, B, 1'b0, x0, x1);
endmodule

// File: rtl/ti_sbox4_pipe.sv
// Two-stage threshold-implementation S-box layer (F then G), each stage registered.
// Optional TI_REMASK_EN adds the rnd port and refreshes the F shares on stage-1 load.
module ti_sbox4_pipe
  import ti_sbox4_pkg::*;
#(
  parameter int NSBOX  = 4,
  parameter int NSHARE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  ti_sbox4_if.slave      bus,
  output logic           busy
`ifdef TI_REMASK_EN
  ,
  input  logic [8*NSBOX-1:0] rnd
`endif
);
  localparam int W = 4 * NSBOX;
  typedef logic [2:0][W-1:0] sh_t;

  if (NSHARE != 3) begin : g_bad_nshare
    $error("ti_sbox4_pipe: NSHARE must be 3");
  end
  if (NSBOX < 1 || NSBOX > 32) begin : g_bad_nsbox
    $error("ti_sbox4_pipe: NSBOX must be 1..32");
  end

  sh_t  f_sh, f_ld, g_sh;
  sh_t  d1_d, d1_q, d2_d, d2_q;
  logic v1_d, v1_q, v2_d, v2_q;
  logic adv1, adv2;

  for (genvar n = 0; n < NSBOX; n++) begin : g_nib
    localparam int L0 = share_lsb(NSBOX, 0, n);
    localparam int L1 = share_lsb(NSBOX, 1, n);
    localparam int L2 = share_lsb(NSBOX, 2, n);

    ti_quad_share4 #(.C0(F_C0), .A(F_A), .B(F_B)) u_f (
      .x0 (bus.in_shares[L0 +: 4]),
      .x1 (bus.in_shares[L1 +: 4]),
      .x2 (bus.in_shares[L2 +: 4]),
      .y0 (f_sh[0][4*n +: 4]),
      .y1 (f_sh[1][4*n +: 4]),
      .y2 (f_sh[2][4*n +: 4])
    );

    ti_quad_share4 #(.C0(G_C0), .A(G_A), .B(G_B)) u_g (
      .x0 (d1_q[0][4*n +: 4]),
      .x1 (d1_q[1][4*n +: 4]),
      .x2 (d1_q[2][4*n +: 4]),
      .y0 (g_sh[0][4*n +: 4]),
      .y1 (g_sh[1][4*n +: 4]),
      .y2 (g_sh[2][4*n +: 4])
    );
  end

  always_comb begin
    f_ld = f_sh;
`ifdef TI_REMASK_EN
    // r0, r1, r0^r1 XOR to zero, so the unshared value is untouched.
    for (int n = 0; n < NSBOX; n++) begin
      f_ld[0][4*n +: 4] = f_sh[0][4*n +: 4] ^ rnd[8*n +: 4];
      f_ld[1][4*n +: 4] = f_sh[1][4*n +: 4] ^ rnd[8*n+4 +: 4];
      f_ld[2][4*n +: 4] = f_sh[2][4*n +: 4] ^ rnd[8*n +: 4] ^ rnd[8*n+4 +: 4];
    end
`endif
  end

  always_comb begin
    adv2 = !v2_q || bus.out_ready;
    adv1 = !v1_q || adv2;
    v1_d = adv1 ? bus.in_valid : v1_q;
    v2_d = adv2 ? v1_q : v2_q;
    d1_d = (adv1 && bus.in_valid) ? f_ld : d1_q;
    d2_d = (adv2 && v1_q) ? g_sh : d2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = v2_q;
  assign bus.out_shares = d2_q;
  assign busy           = v1_q || v2_q;
endmodule

// File: tb/tb_ti_sbox4_pipe.sv
// Directed/randomized bench for ti_sbox4_pipe: scoreboard of unshared S-box results
// derived from SBOX_REF, plus handshake, latency, backpressure and reset checks.
module tb_ti_sbox4_pipe;
  import ti_sbox4_pkg::*;

  localparam int NSBOX = 4;
  localparam int W     = 4 * NSBOX;
  localparam int SW    = 12 * NSBOX;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
`ifdef TI_REMASK_EN
  logic [8*NSBOX-1:0] rnd;
`endif

  ti_sbox4_if #(.NSBOX(NSBOX)) bus ();

  ti_sbox4_pipe #(.NSBOX(NSBOX), .NSHARE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef TI_REMASK_EN
    ,
    .rnd   (rnd)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n_out = 0;
  int first_emit = -1;
  int last_emit = -1;
  int stall_seen = 0;
  logic acc_flag;
  logic last_ov;
  logic [SW-1:0] last_out;
  logic prev_stall = 1'b0;
  logic [SW-1:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] unshare(input logic [SW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < 3; s++) r = r ^ v[share_lsb(NSBOX, s, 0) +: W];
    return r;
  endfunction

  function automatic logic [W-1:0] sbox_all(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int n = 0; n < NSBOX; n++) r[4*n +: 4] = SBOX_REF[x[4*n +: 4]];
    return r;
  endfunction

  function automatic logic [SW-1:0] split(input logic [W-1:0] x);
    logic [W-1:0] s0, s1;
    s0 = W'($urandom);
    s1 = W'($urandom);
    return {x ^ s0 ^ s1, s1, s0};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [W-1:0] x);
    bus.in_valid  = v;
    bus.in_shares = split(x);
  endtask

  // Samples on the falling edge, then returns just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("in_ready", 64'(bus.in_ready), 64'((exp_q.size() < 2) || bus.out_ready));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    if (!bus.in_ready) stall_seen++;
    if (prev_stall) chk("out_hold", 64'(bus.out_shares), 64'(prev_out));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'(bus.out_valid), 64'(0));
      end else begin
        chk("out_value", 64'(unshare(bus.out_shares)), 64'(exp_q[0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
          if (first_emit < 0) first_emit = cyc;
          last_emit = cyc;
        end
      end
    end
    last_ov    = bus.out_valid;
    last_out   = bus.out_shares;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_out   = bus.out_shares;
    acc_flag   = bus.in_valid && bus.in_ready;
    if (acc_flag) exp_q.push_back(sbox_all(unshare(bus.in_shares)));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!last_ov && lat < 8);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int lat;
    int sent;
    logic [W-1:0] x;
    logic iv[10];
    logic ov[10];
`ifdef TI_REMASK_EN
    logic [SW-1:0] sh_fix, out_a, out_b;
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_shares = '0;
    bus.out_ready = 1'b1;
`ifdef TI_REMASK_EN
    rnd = '0;
`endif
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_shares", 64'(bus.out_shares), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // x = 0xC in every nibble as shares (5, A, 3)
    bus.in_valid  = 1'b1;
    bus.in_shares = {16'h3333, 16'hAAAA, 16'h5555};
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("latency", 64'(lat), 64'(2));
    chk("c_value", 64'(unshare(last_out)), 64'(16'h5555));
    drain();

    // every x value in each nibble, back-to-back
    n_out = 0; first_emit = -1; last_emit = -1;
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < NSBOX; n++) x[4*n +: 4] = 4'(i + 4 * n);
      drive(1'b1, x);
      tick();
    end
    drain();
    chk("exh_count", 64'(n_out), 64'(16));
    chk("exh_span", 64'(last_emit - first_emit), 64'(15));

    // five beats with out_ready low for four cycles starting at cycle 3
    n_out = 0; sent = 0; stall_seen = 0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.out_ready = !(k >= 3 && k < 7);
      if (sent < 5) begin
        if (!bus.in_valid) drive(1'b1, W'($urandom));
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (acc_flag) begin
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    drain();
    chk("bp_sent", 64'(sent), 64'(5));
    chk("bp_count", 64'(n_out), 64'(5));
    chk("bp_stall_seen", 64'(stall_seen > 0), 64'(1));

    // in_valid 1,0,1,0,... appears on out_valid two cycles later
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      iv[k] = (k % 2 == 0);
      drive(iv[k], W'($urandom));
      tick();
      ov[k] = last_ov;
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("toggle_%0d", k), 64'(ov[k]), 64'((k >= 2) ? iv[k-2] : 1'b0));
    drain();

    // asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    drive(1'b1, W'($urandom));
    tick();
    drive(1'b1, W'($urandom));
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_shares", 64'(bus.out_shares), 64'(0));
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_rst_busy", 64'(busy), 64'(0));
    bus.out_ready = 1'b1;
    drive(1'b1, W'($urandom));
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("post_rst_latency", 64'(lat), 64'(2));
    drain();

`ifdef TI_REMASK_EN
    // same input shares, zero vs random refresh
    sh_fix = split(W'($urandom));
    rnd = '0;
    bus.in_valid  = 1'b1;
    bus.in_shares = sh_fix;
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    out_a = last_out;
    drain();
    rnd = {$urandom, $urandom} | {(2*NSBOX){4'h1}};
    bus.in_valid  = 1'b1;
    bus.in_shares = sh_fix;
    tick();
    bus.in_valid = 1'b0;
    rnd = '0;
    wait_out(lat);
    out_b = last_out;
    drain();
    chk("remask_unshared", 64'(unshare(out_b)), 64'(unshare(out_a)));
    chk("remask_shares_differ", 64'(out_a != out_b), 64'(1));
`endif

    // final report
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
